// File: rtl/plab3_mem_mem_req_queue_pkg.sv
// Shared memory-request message layout and queue sizing helpers.
package plab3_mem_mem_req_queue_pkg;

  // Memory request message fields, listed from MSB to LSB.
  localparam int unsigned mem_req_type_nbits   = 3;
  localparam int unsigned mem_req_opaque_nbits = 8;
  localparam int unsigned mem_req_addr_nbits   = 32;
  localparam int unsigned mem_req_len_nbits    = 4;
  localparam int unsigned mem_req_data_nbits   = 128;

  localparam int unsigned mem_req_nbits = mem_req_type_nbits + mem_req_opaque_nbits
                                        + mem_req_addr_nbits + mem_req_len_nbits
                                        + mem_req_data_nbits;

  typedef struct packed {
    logic [mem_req_type_nbits-1:0]   msg_type;
    logic [mem_req_opaque_nbits-1:0] opaque;
    logic [mem_req_addr_nbits-1:0]   addr;
    logic [mem_req_len_nbits-1:0]    len;
    logic [mem_req_data_nbits-1:0]   data;
  } mem_req_msg_t;

  // The pointer is at least one bit wide, so a depth-1 queue still has a legal index.
  function automatic int unsigned ptr_width(input int unsigned num_entries);
    return (num_entries > 1) ? $clog2(num_entries) : 1;
  endfunction

  // The count has to hold every value from 0 to num_entries inclusive.
  function automatic int unsigned cnt_width(input int unsigned num_entries);
    return $clog2(num_entries + 1);
  endfunction

endpackage

// File: rtl/plab3_mem_mem_req_queue_ctrl.sv
// Queue control: pointers, occupancy count, handshake outputs and storage addressing.
module plab3_mem_mem_req_queue_ctrl
  import plab3_mem_mem_req_queue_pkg::*;
#(
  parameter int unsigned p_num_entries = 2,
  parameter int unsigned p_pipe        = 0,
  localparam int unsigned ptr_nbits    = ptr_width(p_num_entries),
  localparam int unsigned cnt_nbits    = cnt_width(p_num_entries)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_val,
  output logic                 enq_rdy,
  output logic                 deq_val,
  input  logic                 deq_rdy,
  output logic                 wen,
  output logic [ptr_nbits-1:0] waddr,
  output logic [ptr_nbits-1:0] raddr,
  output logic [cnt_nbits-1:0] num_free_entries
);

  localparam logic [ptr_nbits-1:0] last_idx = ptr_nbits'(p_num_entries - 1);
  localparam logic [cnt_nbits-1:0] depth    = cnt_nbits'(p_num_entries);

  logic [ptr_nbits-1:0] enq_ptr;
  logic [ptr_nbits-1:0] deq_ptr;
  logic [cnt_nbits-1:0] count;
  logic                 full;
  logic                 enq_fire;
  logic                 deq_fire;

  // The handshakes depend only on the registered count. In pipe mode deq_rdy can also
  // open a full queue, because the head entry leaves in the same cycle.
  always_comb begin
    full             = (count == depth);
    deq_val          = (count != '0);
    enq_rdy          = !full || ((p_pipe != 0) && deq_rdy);
    enq_fire         = enq_val && enq_rdy;
    deq_fire         = deq_val && deq_rdy;
    wen              = enq_fire;
    waddr            = enq_ptr;
    raddr            = deq_ptr;
    num_free_entries = depth - count;
  end

  // Pointer and count update. Reset wins over any transfer in the same cycle.
  // NOTE: every register in this block takes a non-blocking assignment, so each read
  // sees the value from before the clock edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (enq_fire) enq_ptr <= (enq_ptr == last_idx) ? '0 : enq_ptr + ptr_nbits'(1);
      if (deq_fire) deq_ptr <= (deq_ptr == last_idx) ? '0 : deq_ptr + ptr_nbits'(1);
      if (enq_fire && !deq_fire)      count <= count + cnt_nbits'(1);
      else if (!enq_fire && deq_fire) count <= count - cnt_nbits'(1);
    end
  end

endmodule

// File: rtl/plab3_mem_mem_req_queue.sv
// Memory request queue between the cache memreq port and memory. It absorbs
// memory backpressure so the cache controller does not have to.
`ifndef PLAB3_MEM_MEM_REQ_QUEUE_V
`define PLAB3_MEM_MEM_REQ_QUEUE_V

module plab3_mem_mem_req_queue
  import plab3_mem_mem_req_queue_pkg::*;
#(
  parameter int unsigned p_msg_nbits   = mem_req_nbits,
  parameter int unsigned p_num_entries = 2,
  parameter int unsigned p_pipe        = 0,
  localparam int unsigned cnt_nbits    = cnt_width(p_num_entries),
  localparam int unsigned ptr_nbits    = ptr_width(p_num_entries)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic [cnt_nbits-1:0]   num_free_entries
);

  logic                   wen;
  logic [ptr_nbits-1:0]   waddr;
  logic [ptr_nbits-1:0]   raddr;
  logic [p_msg_nbits-1:0] entries [p_num_entries];

  plab3_mem_mem_req_queue_ctrl #(
    .p_num_entries (p_num_entries),
    .p_pipe        (p_pipe)
  ) ctrl (
    .clk              (clk),
    .reset            (reset),
    .enq_val          (enq_val),
    .enq_rdy          (enq_rdy),
    .deq_val          (deq_val),
    .deq_rdy          (deq_rdy),
    .wen              (wen),
    .waddr            (waddr),
    .raddr            (raddr),
    .num_free_entries (num_free_entries)
  );

  // Write the accepted message into the slot at the enqueue pointer.
  // NOTE: the entry array has no reset. Every slot is written before the count can make
  // it visible, so a reset would only add a clear path to every storage bit.
  always_ff @(posedge clk) begin
    if (wen) entries[waddr] <= enq_msg;
  end

  // Drive the head entry from registered storage. There is no enqueue bypass.
  always_comb begin
    deq_msg = entries[raddr];
  end

endmodule

`endif

// File: tb/tb_plab3_mem_mem_req_queue.sv
// Directed and randomised checks of the memory request queue, covering a depth-2
// normal queue, a depth-2 pipe queue and a depth-3 normal queue.
module tb_plab3_mem_mem_req_queue;

  localparam int W = 175;
  typedef logic [W-1:0] msg_t;

  logic clk = 1'b0;
  logic reset;

  logic a_enq_val, a_enq_rdy, a_deq_val, a_deq_rdy;
  msg_t a_enq_msg, a_deq_msg;
  logic [1:0] a_nfree;
  logic b_enq_val, b_enq_rdy, b_deq_val, b_deq_rdy;
  msg_t b_enq_msg, b_deq_msg;
  logic [1:0] b_nfree;
  logic c_enq_val, c_enq_rdy, c_deq_val, c_deq_rdy;
  msg_t c_enq_msg, c_deq_msg;
  logic [1:0] c_nfree;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  plab3_mem_mem_req_queue #(.p_msg_nbits(W), .p_num_entries(2), .p_pipe(0)) dut_a (
    .clk(clk), .reset(reset), .enq_val(a_enq_val), .enq_rdy(a_enq_rdy), .enq_msg(a_enq_msg),
    .deq_val(a_deq_val), .deq_rdy(a_deq_rdy), .deq_msg(a_deq_msg), .num_free_entries(a_nfree));

  plab3_mem_mem_req_queue #(.p_msg_nbits(W), .p_num_entries(2), .p_pipe(1)) dut_b (
    .clk(clk), .reset(reset), .enq_val(b_enq_val), .enq_rdy(b_enq_rdy), .enq_msg(b_enq_msg),
    .deq_val(b_deq_val), .deq_rdy(b_deq_rdy), .deq_msg(b_deq_msg), .num_free_entries(b_nfree));

  plab3_mem_mem_req_queue #(.p_msg_nbits(W), .p_num_entries(3), .p_pipe(0)) dut_c (
    .clk(clk), .reset(reset), .enq_val(c_enq_val), .enq_rdy(c_enq_rdy), .enq_msg(c_enq_msg),
    .deq_val(c_deq_val), .deq_rdy(c_deq_rdy), .deq_msg(c_deq_msg), .num_free_entries(c_nfree));

  // Inputs change at the falling edge, outputs are read 1 time unit later, and the
  // state updates at the following rising edge.
  task automatic idle_inputs();
    a_enq_val = 0; a_deq_rdy = 0; a_enq_msg = '0;
    b_enq_val = 0; b_deq_rdy = 0; b_enq_msg = '0;
    c_enq_val = 0; c_deq_rdy = 0; c_enq_msg = '0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    @(negedge clk); @(negedge clk);
    reset = 0; #1;
    checks++; if (a_deq_val !== 1'b0) begin errors++; $display("FAIL reset_a_deq_val: got %0b expected 0", a_deq_val); end
    checks++; if (a_enq_rdy !== 1'b1) begin errors++; $display("FAIL reset_a_enq_rdy: got %0b expected 1", a_enq_rdy); end
    checks++; if (a_nfree !== 2'd2) begin errors++; $display("FAIL reset_a_nfree: got %0d expected 2", a_nfree); end
    checks++; if (b_nfree !== 2'd2) begin errors++; $display("FAIL reset_b_nfree: got %0d expected 2", b_nfree); end
    checks++; if (c_nfree !== 2'd3) begin errors++; $display("FAIL reset_c_nfree: got %0d expected 3", c_nfree); end
    checks++; if (c_deq_val !== 1'b0) begin errors++; $display("FAIL reset_c_deq_val: got %0b expected 0", c_deq_val); end
  endtask

  task automatic test_fill_drain();
    @(negedge clk); a_enq_val = 1; a_enq_msg = msg_t'('hA); a_deq_rdy = 0; #1;
    checks++; if (a_enq_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy0: got %0b expected 1", a_enq_rdy); end
    checks++; if (a_deq_val !== 1'b0) begin errors++; $display("FAIL fill_deq_val0: got %0b expected 0", a_deq_val); end
    @(negedge clk); a_enq_msg = msg_t'('hB); #1;
    checks++; if (a_deq_msg !== msg_t'('hA)) begin errors++; $display("FAIL fill_head1: got %0h expected a", a_deq_msg); end
    checks++; if (a_nfree !== 2'd1) begin errors++; $display("FAIL fill_nfree1: got %0d expected 1", a_nfree); end
    // The queue is now full. Try to overwrite with deq_rdy low, then with deq_rdy high.
    @(negedge clk); a_enq_msg = msg_t'('hF); #1;
    checks++; if (a_enq_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy: got %0b expected 0", a_enq_rdy); end
    checks++; if (a_nfree !== 2'd0) begin errors++; $display("FAIL full_nfree: got %0d expected 0", a_nfree); end
    @(negedge clk); a_deq_rdy = 1; #1;
    checks++; if (a_enq_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_deq: got %0b expected 0", a_enq_rdy); end
    checks++; if (a_deq_msg !== msg_t'('hA)) begin errors++; $display("FAIL hold_head: got %0h expected a", a_deq_msg); end
    @(negedge clk); a_enq_val = 0; #1;
    checks++; if (a_deq_msg !== msg_t'('hB)) begin errors++; $display("FAIL drain_second: got %0h expected b", a_deq_msg); end
    checks++; if (a_nfree !== 2'd1) begin errors++; $display("FAIL drain_nfree: got %0d expected 1", a_nfree); end
    @(negedge clk); a_deq_rdy = 0; #1;
    checks++; if (a_deq_val !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0b expected 0", a_deq_val); end
    checks++; if (a_nfree !== 2'd2) begin errors++; $display("FAIL drain_nfree2: got %0d expected 2", a_nfree); end
  endtask

  task automatic test_empty_enq_deq();
    @(negedge clk); a_enq_val = 1; a_enq_msg = msg_t'('h5); a_deq_rdy = 1; #1;
    checks++; if (a_deq_val !== 1'b0) begin errors++; $display("FAIL nobypass_val: got %0b expected 0", a_deq_val); end
    checks++; if (a_enq_rdy !== 1'b1) begin errors++; $display("FAIL nobypass_rdy: got %0b expected 1", a_enq_rdy); end
    @(negedge clk); a_enq_val = 0; #1;
    checks++; if (a_deq_val !== 1'b1) begin errors++; $display("FAIL latency_val: got %0b expected 1", a_deq_val); end
    checks++; if (a_deq_msg !== msg_t'('h5)) begin errors++; $display("FAIL latency_msg: got %0h expected 5", a_deq_msg); end
    @(negedge clk); a_deq_rdy = 0; #1;
    checks++; if (a_deq_val !== 1'b0) begin errors++; $display("FAIL latency_drained: got %0b expected 0", a_deq_val); end
  endtask

  task automatic test_pipe_full();
    @(negedge clk); b_enq_val = 1; b_enq_msg = msg_t'('h1); b_deq_rdy = 0;
    @(negedge clk); b_enq_msg = msg_t'('h2);
    @(negedge clk); b_enq_val = 0; #1;
    checks++; if (b_enq_rdy !== 1'b0) begin errors++; $display("FAIL pipe_full_nordy: got %0b expected 0", b_enq_rdy); end
    checks++; if (b_nfree !== 2'd0) begin errors++; $display("FAIL pipe_full_nfree: got %0d expected 0", b_nfree); end
    @(negedge clk); b_enq_val = 1; b_enq_msg = msg_t'('hC); b_deq_rdy = 1; #1;
    checks++; if (b_enq_rdy !== 1'b1) begin errors++; $display("FAIL pipe_rdy: got %0b expected 1", b_enq_rdy); end
    checks++; if (b_deq_msg !== msg_t'('h1)) begin errors++; $display("FAIL pipe_head: got %0h expected 1", b_deq_msg); end
    @(negedge clk); b_enq_val = 0; b_deq_rdy = 0; #1;
    checks++; if (b_nfree !== 2'd0) begin errors++; $display("FAIL pipe_count: got %0d expected 0", b_nfree); end
    checks++; if (b_deq_msg !== msg_t'('h2)) begin errors++; $display("FAIL pipe_second: got %0h expected 2", b_deq_msg); end
    @(negedge clk); b_deq_rdy = 1;
    @(negedge clk); #1;
    checks++; if (b_deq_msg !== msg_t'('hC)) begin errors++; $display("FAIL pipe_third: got %0h expected c", b_deq_msg); end
    checks++; if (b_nfree !== 2'd1) begin errors++; $display("FAIL pipe_nfree1: got %0d expected 1", b_nfree); end
    @(negedge clk); b_deq_rdy = 0; #1;
    checks++; if (b_deq_val !== 1'b0) begin errors++; $display("FAIL pipe_drained: got %0b expected 0", b_deq_val); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    while (recv < 10 && cyc < 200) begin
      @(negedge clk);
      c_enq_val = (sent < 10); c_enq_msg = msg_t'(sent); c_deq_rdy = cyc[0]; #1;
      checks++; if (c_enq_rdy !== ((sent - recv) != 3)) begin errors++; $display("FAIL b2b_rdy: got %0b expected %0b", c_enq_rdy, ((sent - recv) != 3)); end
      checks++; if (c_deq_val !== ((sent - recv) != 0)) begin errors++; $display("FAIL b2b_val: got %0b expected %0b", c_deq_val, ((sent - recv) != 0)); end
      if (c_deq_val && c_deq_rdy) begin
        checks++; if (c_deq_msg !== msg_t'(recv)) begin errors++; $display("FAIL b2b_order: got %0h expected %0h", c_deq_msg, recv); end
        recv++;
      end
      if (c_enq_val && c_enq_rdy) sent++;
      cyc++;
    end
    checks++; if (recv != 10) begin errors++; $display("FAIL b2b_timeout: got %0d messages expected 10", recv); end
    @(negedge clk); c_enq_val = 0; c_deq_rdy = 0; #1;
    checks++; if (c_deq_val !== 1'b0) begin errors++; $display("FAIL b2b_extra: got %0b expected 0", c_deq_val); end
    checks++; if (c_nfree !== 2'd3) begin errors++; $display("FAIL b2b_nfree: got %0d expected 3", c_nfree); end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk); a_enq_val = 1; a_enq_msg = msg_t'('h11); a_deq_rdy = 0;
    @(negedge clk); a_enq_msg = msg_t'('h22);
    @(negedge clk); a_enq_msg = msg_t'('h33); a_deq_rdy = 1; reset = 1;
    @(negedge clk); reset = 0; a_enq_val = 0; a_deq_rdy = 0; #1;
    checks++; if (a_deq_val !== 1'b0) begin errors++; $display("FAIL rst_fly_val: got %0b expected 0", a_deq_val); end
    checks++; if (a_enq_rdy !== 1'b1) begin errors++; $display("FAIL rst_fly_rdy: got %0b expected 1", a_enq_rdy); end
    checks++; if (a_nfree !== 2'd2) begin errors++; $display("FAIL rst_fly_nfree: got %0d expected 2", a_nfree); end
    @(negedge clk); a_deq_rdy = 1; #1;
    checks++; if (a_deq_val !== 1'b0) begin errors++; $display("FAIL rst_fly_emit: got %0b expected 0", a_deq_val); end
    a_deq_rdy = 0;
  endtask

  task automatic test_random();
    msg_t qa[$];
    msg_t qb[$];
    logic [191:0] raw;
    logic exp_rdy;
    reset = 1; idle_inputs();
    @(negedge clk); reset = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      raw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      a_enq_val = 1'($urandom_range(0, 1)); a_deq_rdy = 1'($urandom_range(0, 1)); a_enq_msg = raw[W-1:0];
      raw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b_enq_val = 1'($urandom_range(0, 1)); b_deq_rdy = 1'($urandom_range(0, 1)); b_enq_msg = raw[W-1:0];
      #1;
      exp_rdy = (qa.size() != 2);
      checks++; if (a_enq_rdy !== exp_rdy) begin errors++; $display("FAIL rand_a_rdy cyc %0d: got %0b expected %0b", i, a_enq_rdy, exp_rdy); end
      checks++; if (a_deq_val !== (qa.size() != 0)) begin errors++; $display("FAIL rand_a_val cyc %0d: got %0b expected %0b", i, a_deq_val, (qa.size() != 0)); end
      checks++; if (a_nfree !== 2'(2 - qa.size())) begin errors++; $display("FAIL rand_a_nfree cyc %0d: got %0d expected %0d", i, a_nfree, 2 - qa.size()); end
      if (qa.size() != 0) begin
        checks++; if (a_deq_msg !== qa[0]) begin errors++; $display("FAIL rand_a_msg cyc %0d: got %0h expected %0h", i, a_deq_msg, qa[0]); end
      end
      if (qa.size() != 0 && a_deq_rdy) void'(qa.pop_front());
      if (a_enq_val && exp_rdy) qa.push_back(a_enq_msg);

      exp_rdy = (qb.size() != 2) || b_deq_rdy;
      checks++; if (b_enq_rdy !== exp_rdy) begin errors++; $display("FAIL rand_b_rdy cyc %0d: got %0b expected %0b", i, b_enq_rdy, exp_rdy); end
      checks++; if (b_deq_val !== (qb.size() != 0)) begin errors++; $display("FAIL rand_b_val cyc %0d: got %0b expected %0b", i, b_deq_val, (qb.size() != 0)); end
      checks++; if (b_nfree !== 2'(2 - qb.size())) begin errors++; $display("FAIL rand_b_nfree cyc %0d: got %0d expected %0d", i, b_nfree, 2 - qb.size()); end
      if (qb.size() != 0) begin
        checks++; if (b_deq_msg !== qb[0]) begin errors++; $display("FAIL rand_b_msg cyc %0d: got %0h expected %0h", i, b_deq_msg, qb[0]); end
      end
      if (qb.size() != 0 && b_deq_rdy) void'(qb.pop_front());
      if (b_enq_val && exp_rdy) qb.push_back(b_enq_msg);
    end
    idle_inputs();
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_empty_enq_deq();
    test_pipe_full();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plab3_mem_mem_req_queue.md
PLAB3_MEM_MEM_REQ_QUEUE -- requirements
Module: plab3_mem_MemReqQueue

Interface
REQ-001 Parameters, one per line: p_msg_nbits, 175 (vc-mem-msgs request width: type 3, opaque 8, addr 32, len 4, data 128), message width in bits.
REQ-002 p_num_entries, 2, queue depth; legal range 1..16.
REQ-003 p_pipe, 0, 0 = normal queue, 1 = pipe queue (enqueue accepted when full if dequeue fires in the same cycle).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enq_val  input  1  upstream (cache memreq side) request valid.
REQ-007 enq_rdy  output  1  queue can accept this cycle.
REQ-008 enq_msg  input  p_msg_nbits  request message.
REQ-009 deq_val  output  1  head entry valid toward memory.
REQ-010 deq_rdy  input  1  memory accepts head this cycle.
REQ-011 deq_msg  output  p_msg_nbits  head entry message.
REQ-012 num_free_entries  output  $clog2(p_num_entries+1)  count of empty slots.

Function
REQ-013 Block sits between cache memreq_val/memreq_rdy/memreq_msg and memory; it decouples memory backpressure from the cache controller.
REQ-014 Enqueue fire = enq_val && enq_rdy; dequeue fire = deq_val && deq_rdy; transfers occur only on fire.
REQ-015 Storage: p_num_entries registers, enq_ptr, deq_ptr, count (0..p_num_entries).
REQ-016 Pointers wrap from p_num_entries-1 to 0 (explicit compare, not power-of-two masking).
REQ-017 deq_val = (count != 0); deq_msg = entry[deq_ptr]; no bypass: enqueued message appears on deq no earlier than next cycle (latency 1).
REQ-018 p_pipe=0: enq_rdy = (count != p_num_entries).
REQ-019 p_pipe=1: enq_rdy = (count != p_num_entries) || deq_rdy.
REQ-020 Count update: enq only +1; deq only -1; both fire, count unchanged, both pointers advance.
REQ-021 Empty with enq_val and deq_rdy both high: enqueue only; deq_val stays 0 that cycle.
REQ-022 Full with p_pipe=0: enq_rdy=0 regardless of deq_rdy; entry not overwritten.
REQ-023 Order strictly FIFO; messages unmodified bit-for-bit.
REQ-024 num_free_entries = p_num_entries - count, registered-state derived, no dependence on same-cycle inputs.
REQ-025 deq_msg held stable while deq_val=1 and deq_rdy=0.

Reset
REQ-026 reset high at posedge: count=0, enq_ptr=0, deq_ptr=0; next cycle deq_val=0, enq_rdy=1, num_free_entries=p_num_entries.
REQ-027 Reset dominates any same-cycle fire; in-flight entries discarded, no dequeue reported.
REQ-028 Entry data registers not reset; deq_msg is don't-care while deq_val=0.

Structure
REQ-029 Message width constants and field layout come from the shared vc-mem-msgs header; no local redefinition.
REQ-030 One sub-module: plab3_mem_MemReqQueueCtrl holding pointers, count, enq_rdy/deq_val, write-enable and read-select outputs; top holds the entry array and muxing.
REQ-031 Header guard macro PLAB3_MEM_MEM_REQ_QUEUE_V.

Verification
REQ-032 Depth 2, p_pipe=0: enqueue 0xA, 0xB with deq_rdy=0 -> enq_rdy=0 after 2nd, num_free_entries=0; deq_rdy=1 -> 0xA then 0xB, in order.
REQ-033 Empty, enq_val=1 msg 0x5, deq_rdy=1 -> deq_val=0 same cycle, deq_val=1 deq_msg=0x5 next cycle.
REQ-034 Full depth 2, p_pipe=1, enq_val=1 msg 0xC, deq_rdy=1 -> both fire, count stays 2, subsequent order 2nd-entry, 0xC.
REQ-035 Depth 3: 10 back-to-back messages 0..9 with deq_rdy toggling every cycle -> output 0..9 exactly once, pointers wrap correctly.
REQ-036 Queue holding 2 entries, reset asserted with enq_val=1 -> next cycle deq_val=0, enq_rdy=1, num_free_entries=2; no message emitted.
REQ-037 Random val/rdy for 1000 cycles vs scoreboard FIFO -> zero mismatches, no loss or duplication.
